// File: rtl/video_pkg.sv
// Shared definitions for the VGA synchronization core: default resolution
// and the frame sequencer state encoding.
package video_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } fsq_state_t;

endpackage

// File: rtl/frame_counter.sv
// Raster position counter: advances one pixel per inc, wraps at frame end.
// sync_clr has priority over inc; position updates the cycle after the request.
module frame_counter
  import video_pkg::*;
#(
  parameter int HMAX = H_ACTIVE,
  parameter int VMAX = V_ACTIVE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inc,
  input  logic        sync_clr,
  output logic [10:0] hcount,
  output logic [10:0] vcount,
  output logic        frame_start,
  output logic        frame_end
);

  logic [10:0] h_q;
  logic [10:0] v_q;
  logic        line_end;
  logic        last_line;

  assign line_end    = (h_q == 11'(HMAX - 1));
  assign last_line   = (v_q == 11'(VMAX - 1));
  assign frame_start = (h_q == 11'd0) && (v_q == 11'd0);
  assign frame_end   = line_end && last_line;
  assign hcount      = h_q;
  assign vcount      = v_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_q <= 11'd0;
      v_q <= 11'd0;
    end else if (sync_clr) begin
      h_q <= 11'd0;
      v_q <= 11'd0;
    end else if (inc) begin
      if (line_end) begin
        h_q <= 11'd0;
        v_q <= last_line ? 11'd0 : v_q + 11'd1;
      end else begin
        h_q <= h_q + 11'd1;
      end
    end
  end

endmodule

// File: rtl/frame_seq_ctrl.sv
// Frame sequencer: runs whole frames from (0,0), first slot two cycles after start,
// done one cycle after the last eof; pix_ready low holds the offered slot unchanged.
module frame_seq_ctrl
  import video_pkg::*;
#(
  parameter int HMAX = H_ACTIVE,
  parameter int VMAX = V_ACTIVE,
  parameter int FCW  = 16
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic           stop,
  input  logic [FCW-1:0] num_frames,
  output logic           busy,
  output logic           done,
  output logic [FCW-1:0] frames_done,
  output logic           pix_valid,
  input  logic           pix_ready,
  output logic           pix_sof,
  output logic           pix_eof,
  output logic [10:0]    hcount,
  output logic [10:0]    vcount
);

  fsq_state_t     state_q, state_d;
  logic [FCW-1:0] frames_done_q;
  logic [FCW-1:0] frames_next;
  logic [FCW-1:0] target_q;
  logic           stop_pend;
  logic           done_q;
  logic           cnt_inc;
  logic           cnt_sync_clr;
  logic           frame_start;
  logic           frame_end;
  logic           frame_cmpl;
  logic           target_hit;
  logic           run_exit;
  logic           start_acc;

  frame_counter #(
    .HMAX (HMAX),
    .VMAX (VMAX)
  ) u_frame_counter (
    .clk         (clk),
    .reset       (reset),
    .inc         (cnt_inc),
    .sync_clr    (cnt_sync_clr),
    .hcount      (hcount),
    .vcount      (vcount),
    .frame_start (frame_start),
    .frame_end   (frame_end)
  );

  assign pix_valid   = (state_q == RUN) || (state_q == DRAIN);
  assign cnt_inc     = pix_valid & pix_ready;
  assign pix_sof     = pix_valid & frame_start;
  assign pix_eof     = pix_valid & frame_end;
  assign frame_cmpl  = cnt_inc & frame_end;
  assign frames_next = frames_done_q + FCW'(1);
  assign target_hit  = (target_q != '0) && (frames_next == target_q);
  assign start_acc   = (state_q == IDLE) && start;
  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign frames_done = frames_done_q;

  always_comb begin
    state_d      = state_q;
    cnt_sync_clr = 1'b0;
    run_exit     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = CLEAR;
      end
      CLEAR: begin
        cnt_sync_clr = 1'b1;
        state_d      = (stop || stop_pend) ? DRAIN : RUN;
      end
      RUN: begin
        // A stop landing on the completing slot ends the run right there.
        if (frame_cmpl && (target_hit || stop)) begin
          state_d  = IDLE;
          run_exit = 1'b1;
        end else if (stop) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (frame_cmpl) begin
          state_d  = IDLE;
          run_exit = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      done_q        <= 1'b0;
      frames_done_q <= '0;
      target_q      <= '0;
      stop_pend     <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= run_exit;
      if (start_acc) begin
        frames_done_q <= '0;
        target_q      <= num_frames;
        stop_pend     <= 1'b0;
      end else begin
        if (frame_cmpl) frames_done_q <= frames_next;
        if ((state_q == CLEAR) && stop) stop_pend <= 1'b1;
      end
    end
  end

endmodule
